// File: rtl/param_sync_fifo_pkg.sv
// rtl/param_sync_fifo_pkg.sv - shared FIFO constants and helpers
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Threshold compare shared by every FIFO that reports a water level.
  function automatic logic level_ge(input int unsigned level, input int unsigned threshold);
    return level >= threshold;
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// rtl/param_sync_fifo_if.sv - write/read/status bundle of the sample-path FIFO
interface param_sync_fifo_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 10
);
  logic                   flush;
  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   wr_full;
  logic                   almost_full;
  logic                   rd_en;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   rd_valid;
  logic                   rd_empty;
  logic                   almost_empty;
  logic [DEPTH_WIDTH:0]   water_level;
  logic                   overflow;
  logic                   underflow;
  logic                   err_clr;

  modport master (
    output flush, wr_en, wr_data, rd_en, err_clr,
    input  wr_full, almost_full, rd_data, rd_valid, rd_empty, almost_empty,
           water_level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, err_clr,
    output wr_full, almost_full, rd_data, rd_valid, rd_empty, almost_empty,
           water_level, overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo_ram_sdp.sv
// rtl/param_sync_fifo_ram_sdp.sv - simple dual-port RAM, one write port, one registered read port
module fifo_ram_sdp #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   i_wr_en,
  input  logic [DEPTH_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]  i_wr_data,
  input  logic                   i_rd_en,
  input  logic [DEPTH_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0]  o_rd_data
);
  logic [DATA_WIDTH-1:0] r_mem [0:(1<<DEPTH_WIDTH)-1];

  // No reset on storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end
endmodule

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parametrised single-clock FIFO with optional first-word-fall-through
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int          DATA_WIDTH       = 8,
  parameter int          DEPTH_WIDTH      = 10,
  parameter int          FWFT             = 0,
  parameter int unsigned ALMOST_FULL_NUM  = 900,
  parameter int unsigned ALMOST_EMPTY_NUM = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  param_sync_fifo_if.slave bus
);
  localparam int              LW      = DEPTH_WIDTH + 1;
  localparam logic [LW-1:0]   DEPTH   = LW'(1 << DEPTH_WIDTH);
  localparam bit              IS_FWFT = (FWFT == FIFO_MODE_FWFT);
  localparam bit              AF_RST  = (ALMOST_FULL_NUM == 0);

  logic [LW-1:0]         r_wptr, r_rptr, r_level;
  logic                  r_full, r_afull, r_empty, r_aempty;
  logic                  r_vld, r_has_data, r_ovf, r_unf;

  logic                  w_wr_acc, w_rd_acc, w_ram_empty, w_ram_rd, w_vld_nxt;
  logic [LW-1:0]         w_level_nxt;
  logic [DATA_WIDTH-1:0] w_ram_q;

  // In FWFT mode the RAM read register is the output stage; it refills whenever it
  // is empty or being popped, so back-to-back pops stream at one word per clock.
  always_comb begin
    w_wr_acc    = bus.wr_en & ~r_full & ~bus.flush;
    w_rd_acc    = bus.rd_en & ~r_empty & ~bus.flush;
    w_ram_empty = (r_wptr == r_rptr);
    w_ram_rd    = w_rd_acc;
    w_vld_nxt   = w_rd_acc;
    if (IS_FWFT) begin
      w_ram_rd  = ~w_ram_empty & (~r_vld | w_rd_acc) & ~bus.flush;
      w_vld_nxt = w_ram_rd | (r_vld & ~w_rd_acc);
    end
    w_level_nxt = r_level + LW'(w_wr_acc) - LW'(w_rd_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_afull    <= AF_RST;
      r_empty    <= 1'b1;
      r_aempty   <= 1'b1;
      r_vld      <= 1'b0;
      r_has_data <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      // A fresh error outranks a simultaneous clear.
      r_ovf <= (bus.wr_en & r_full & ~bus.flush) | (r_ovf & ~bus.err_clr);
      r_unf <= (bus.rd_en & r_empty & ~bus.flush) | (r_unf & ~bus.err_clr);
      if (bus.flush) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_level    <= '0;
        r_full     <= 1'b0;
        r_afull    <= AF_RST;
        r_empty    <= 1'b1;
        r_aempty   <= 1'b1;
        r_vld      <= 1'b0;
        r_has_data <= 1'b0;
      end else begin
        if (w_wr_acc) r_wptr <= r_wptr + LW'(1);
        if (w_ram_rd) begin
          r_rptr     <= r_rptr + LW'(1);
          r_has_data <= 1'b1;
        end
        r_level  <= w_level_nxt;
        r_full   <= (w_level_nxt == DEPTH);
        r_afull  <= level_ge(32'(w_level_nxt), ALMOST_FULL_NUM);
        r_aempty <= level_ge(ALMOST_EMPTY_NUM, 32'(w_level_nxt));
        r_empty  <= IS_FWFT ? ~w_vld_nxt : (w_level_nxt == '0);
        r_vld    <= w_vld_nxt;
      end
    end
  end

  fifo_ram_sdp #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WIDTH (DEPTH_WIDTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wptr[DEPTH_WIDTH-1:0]),
    .i_wr_data (bus.wr_data),
    .i_rd_en   (w_ram_rd),
    .i_rd_addr (r_rptr[DEPTH_WIDTH-1:0]),
    .o_rd_data (w_ram_q)
  );

  assign bus.wr_full      = r_full;
  assign bus.almost_full  = r_afull;
  assign bus.rd_empty     = r_empty;
  assign bus.almost_empty = r_aempty;
  assign bus.water_level  = r_level;
  assign bus.rd_valid     = r_vld;
  assign bus.rd_data      = r_has_data ? w_ram_q : '0;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_unf;
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - standard and FWFT instances against a queue-based reference model
module tb_param_sync_fifo;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, wr_en, rd_en, err_clr;
  logic [DW-1:0] wr_data;
  int            n_checks = 0;
  int            n_fail   = 0;

  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) if_s ();
  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) if_f ();

  assign if_s.flush = flush;   assign if_f.flush = flush;
  assign if_s.wr_en = wr_en;   assign if_f.wr_en = wr_en;
  assign if_s.wr_data = wr_data; assign if_f.wr_data = wr_data;
  assign if_s.rd_en = rd_en;   assign if_f.rd_en = rd_en;
  assign if_s.err_clr = err_clr; assign if_f.err_clr = err_clr;

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(FIFO_MODE_STD),
                    .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE))
    u_std (.clk(clk), .rst_n(rst_n), .bus(if_s));
  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(FIFO_MODE_FWFT),
                    .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE))
    u_fwft (.clk(clk), .rst_n(rst_n), .bus(if_f));

  always #5 clk = ~clk;

  // Reference: each FIFO is an ordered queue of held words; FWFT head visibility
  // only requires that a word was already held before the current edge.
  logic [DW-1:0] q_s[$];
  logic [DW-1:0] q_f[$];
  logic [DW-1:0] dat_s;
  bit vld_s, vld_f, ovf_s, unf_s, ovf_f, unf_f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q_s.delete(); q_f.delete();
    dat_s = '0; vld_s = 0; vld_f = 0;
    ovf_s = 0; unf_s = 0; ovf_f = 0; unf_f = 0;
  endtask

  task automatic model_edge();
    bit full, empty;
    if (!rst_n) begin
      model_reset();
    end else if (flush) begin
      q_s.delete(); q_f.delete();
      dat_s = '0; vld_s = 0; vld_f = 0;
      ovf_s = ovf_s && !err_clr; unf_s = unf_s && !err_clr;
      ovf_f = ovf_f && !err_clr; unf_f = unf_f && !err_clr;
    end else begin
      full  = (q_s.size() == D);
      empty = (q_s.size() == 0);
      ovf_s = (wr_en && full)  || (ovf_s && !err_clr);
      unf_s = (rd_en && empty) || (unf_s && !err_clr);
      vld_s = rd_en && !empty;
      if (vld_s) dat_s = q_s.pop_front();
      if (wr_en && !full) q_s.push_back(wr_data);

      full  = (q_f.size() == D);
      empty = !vld_f;
      ovf_f = (wr_en && full)  || (ovf_f && !err_clr);
      unf_f = (rd_en && empty) || (unf_f && !err_clr);
      if (rd_en && vld_f) void'(q_f.pop_front());
      vld_f = (q_f.size() > 0);
      if (wr_en && !full) q_f.push_back(wr_data);
    end
  endtask

  task automatic compare_all();
    check("s_level", 32'(if_s.water_level),  32'(q_s.size()));
    check("s_full",  32'(if_s.wr_full),      32'(q_s.size() == D));
    check("s_afull", 32'(if_s.almost_full),  32'(q_s.size() >= AF));
    check("s_aempt", 32'(if_s.almost_empty), 32'(q_s.size() <= AE));
    check("s_empty", 32'(if_s.rd_empty),     32'(q_s.size() == 0));
    check("s_valid", 32'(if_s.rd_valid),     32'(vld_s));
    check("s_data",  32'(if_s.rd_data),      32'(dat_s));
    check("s_ovf",   32'(if_s.overflow),     32'(ovf_s));
    check("s_unf",   32'(if_s.underflow),    32'(unf_s));
    check("f_level", 32'(if_f.water_level),  32'(q_f.size()));
    check("f_full",  32'(if_f.wr_full),      32'(q_f.size() == D));
    check("f_afull", 32'(if_f.almost_full),  32'(q_f.size() >= AF));
    check("f_aempt", 32'(if_f.almost_empty), 32'(q_f.size() <= AE));
    check("f_empty", 32'(if_f.rd_empty),     32'(!vld_f));
    check("f_valid", 32'(if_f.rd_valid),     32'(vld_f));
    if (vld_f) check("f_data", 32'(if_f.rd_data), 32'(q_f[0]));
    check("f_ovf",   32'(if_f.overflow),     32'(ovf_f));
    check("f_unf",   32'(if_f.underflow),    32'(unf_f));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit w, input bit r, input logic [DW-1:0] d);
    wr_en = w; rd_en = r; wr_data = d;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("rst_level", 32'(if_f.water_level), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < D; i++) begin
      drive(1, 0, 8'(8'hFF - i));
      if (i == 10) check("af_before12", 32'(if_s.almost_full), 32'd0);
      if (i == 11) check("af_at12", 32'(if_f.almost_full), 32'd1);
    end
    check("fill_level", 32'(if_s.water_level), 32'd16);
    check("fill_full",  32'(if_f.wr_full), 32'd1);
    drive(1, 0, 8'h00);
    check("ovf_17th", 32'(if_s.overflow), 32'd1);
    check("lvl_17th", 32'(if_f.water_level), 32'd16);

    drive(1, 1, 8'h11);
    check("full_rw_s", 32'(if_s.water_level), 32'd15);
    check("full_rw_f", 32'(if_f.water_level), 32'd15);

    for (int i = 0; i < 17; i++) drive(0, 1, 8'h00);
    check("drain_unf", 32'(if_s.underflow), 32'd1);
    check("drain_vld", 32'(if_s.rd_valid), 32'd0);
    err_clr = 1'b1; drive(0, 0, 8'h00); err_clr = 1'b0;
    check("errclr_ovf", 32'(if_f.overflow), 32'd0);

    for (int i = 0; i < 8; i++) drive(1, 0, 8'(i));
    drive(0, 0, 8'h00);
    for (int i = 0; i < 100; i++) drive(1, 1, 8'(i + 8));
    check("lvl8_s", 32'(if_s.water_level), 32'd8);
    check("lvl8_f", 32'(if_f.water_level), 32'd8);

    flush = 1'b1; drive(0, 0, 8'h00); flush = 1'b0;
    drive(1, 0, 8'hA5);
    check("a5_notyet", 32'(if_f.rd_valid), 32'd0);
    drive(0, 0, 8'h00);
    check("a5_valid", 32'(if_f.rd_valid), 32'd1);
    check("a5_data",  32'(if_f.rd_data), 32'hA5);
    drive(0, 1, 8'h00);
    check("a5_empty", 32'(if_f.rd_empty), 32'd1);

    for (int i = 0; i < 17; i++) drive(1, 0, 8'(8'h30 + i));
    for (int i = 0; i < 6; i++) drive(0, 1, 8'h00);
    flush = 1'b1; drive(1, 1, 8'hEE); flush = 1'b0;
    check("flush_lvl",   32'(if_s.water_level), 32'd0);
    check("flush_empty", 32'(if_f.rd_empty), 32'd1);
    check("flush_ovf",   32'(if_f.overflow), 32'd1);
    drive(1, 0, 8'h77); drive(0, 0, 8'h00); drive(0, 1, 8'h00); drive(0, 0, 8'h00);
    err_clr = 1'b1; drive(0, 0, 8'h00); err_clr = 1'b0;

    for (int i = 0; i < 17; i++) drive(1, 0, 8'($urandom));
    drive(1, 1, 8'($urandom));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_ovf", 32'(if_s.overflow), 32'd0);
    step(); step();
    rst_n = 1'b1;

    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 300; i++) begin
        flush   = ($urandom_range(0, 96) == 0);
        err_clr = ($urandom_range(0, 40) == 0);
        drive($urandom_range(0, 99) < 70 - 20 * ph,
              $urandom_range(0, 99) < 30 + 20 * ph,
              8'($urandom));
      end
    end
    flush = 1'b0; err_clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
